imem_port_arbiter: RTL and testbench

Arbiter that shares the single-port, synchronous-read instruction memory between the CPU fetch stage and the CPU data-side port (loads of constants from the text segment, and program-image writes). Sits between the core and the memory array; the memory keeps its one-cycle registered read. The block grants one requester per cycle, routes the read response back one cycle later, and bounds fetch starvation with a streak counter. It also rejects misaligned or out-of-range addresses without touching the array.

---
 rtl/imem_pkg.sv | 26 ++
 rtl/imem_addr_check.sv | 32 +++
 rtl/imem_port_arbiter.sv | 150 +++++++++++++++
 tb/tb_imem_port_arbiter.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/imem_pkg.sv
`default_nettype none
// ============================================================================
// Module      : imem_pkg
// Description : Shared constants and types for the instruction-memory
//               subsystem. The default geometry is also used by the memory
//               array and by the core.
// Revision    : 1.0 - initial release
// ============================================================================
package imem_pkg;

    // ADDI x0, x0, 0: returned in place of a fetch that could not be served
    localparam logic [31:0] NOP_INSN = 32'h0000_0013;

    // Default memory geometry
    localparam int IMEM_DEPTH  = 24581;
    localparam int IMEM_ADDR_W = 15;

    // Which requester the registered response belongs to
    typedef enum logic [1:0] {
        OWN_NONE  = 2'd0,
        OWN_FETCH = 2'd1,
        OWN_DATA  = 2'd2
    } owner_e;

endpackage : imem_pkg
`default_nettype wire

// File: rtl/imem_addr_check.sv
`default_nettype none
// ============================================================================
// Module      : imem_addr_check
// Description : Combinational byte-address to word-index conversion with
//               alignment and range checking.
//   addr  in  32      byte address
//   index out ADDR_W  word index (addr >> 2, truncated)
//   bad   out 1       misaligned, upper bits set, or index >= DEPTH
// Revision    : 1.0 - initial release
// ============================================================================
module imem_addr_check #(
    parameter int ADDR_W = 15,
    parameter int DEPTH  = 24581
) (
    input  logic [31:0]       addr,
    output logic [ADDR_W-1:0] index,
    output logic              bad
);

    logic w_misaligned;
    logic w_upper_set;
    logic w_past_end;

    assign index        = addr[ADDR_W+1:2];
    assign w_misaligned = (addr[1:0] != 2'b00);
    // Any set bit above the index field would alias onto a lower word
    assign w_upper_set  = ((addr >> (ADDR_W + 2)) != 32'd0);
    assign w_past_end   = (32'(index) >= 32'(DEPTH));
    assign bad          = w_misaligned | w_upper_set | w_past_end;

endmodule : imem_addr_check
`default_nettype wire

// File: rtl/imem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : imem_port_arbiter
// Description : Shares the single-port synchronous-read instruction memory
//               between the fetch port and the data port. One grant per
//               cycle, response routed back one cycle later, fetch
//               starvation bounded by a data-grant streak counter. Bad
//               addresses never reach the array and return an error.
//   clk, rst_n                       clock, async active-low reset
//   f_req/f_addr -> f_gnt            fetch request / accept
//   f_rvalid/f_rdata/f_err           fetch response
//   d_req/d_we/d_addr/d_wdata->d_gnt data request / accept
//   d_rvalid/d_rdata/d_err           data response / write ack
//   m_en/m_we/m_addr/m_wdata/m_rdata memory array port
// Revision    : 1.0 - initial release
// ============================================================================
module imem_port_arbiter
    import imem_pkg::*;
#(
    parameter int ADDR_W      = IMEM_ADDR_W,
    parameter int DEPTH       = IMEM_DEPTH,
    parameter int MAX_DSTREAK = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    // fetch port
    input  logic              f_req,
    input  logic [31:0]       f_addr,
    output logic              f_gnt,
    output logic              f_rvalid,
    output logic [31:0]       f_rdata,
    output logic              f_err,
    // data port
    input  logic              d_req,
    input  logic              d_we,
    input  logic [31:0]       d_addr,
    input  logic [31:0]       d_wdata,
    output logic              d_gnt,
    output logic              d_rvalid,
    output logic [31:0]       d_rdata,
    output logic              d_err,
    // memory port
    output logic              m_en,
    output logic              m_we,
    output logic [ADDR_W-1:0] m_addr,
    output logic [31:0]       m_wdata,
    input  logic [31:0]       m_rdata
);

    localparam logic [3:0] c_max_streak = 4'(MAX_DSTREAK);

    logic [ADDR_W-1:0] w_f_index;
    logic [ADDR_W-1:0] w_d_index;
    logic              w_f_bad;
    logic              w_d_bad;
    logic              w_f_turn;
    logic              w_any_gnt;
    logic              w_gnt_bad;
    logic [ADDR_W-1:0] w_gnt_index;

    logic [3:0]        r_streak;
    owner_e            r_owner;
    logic              r_was_write;
    logic              r_was_bad;

    imem_addr_check #(
        .ADDR_W (ADDR_W),
        .DEPTH  (DEPTH)
    ) u_f_check (
        .addr   (f_addr),
        .index  (w_f_index),
        .bad    (w_f_bad)
    );

    imem_addr_check #(
        .ADDR_W (ADDR_W),
        .DEPTH  (DEPTH)
    ) u_d_check (
        .addr   (d_addr),
        .index  (w_d_index),
        .bad    (w_d_bad)
    );

    // ------------------------------------------------------------------
    // Arbitration: data has priority until fetch has watched MAX_DSTREAK
    // data grants go by, then fetch takes one slot.
    // ------------------------------------------------------------------
    assign w_f_turn    = f_req && (r_streak == c_max_streak);
    assign d_gnt       = d_req && !w_f_turn;
    assign f_gnt       = f_req && !d_gnt;
    assign w_any_gnt   = f_gnt || d_gnt;
    assign w_gnt_bad   = f_gnt ? w_f_bad : w_d_bad;
    assign w_gnt_index = f_gnt ? w_f_index : w_d_index;

    // Bad requests are still granted (so the requester gets an error
    // response) but never enable the array, which suppresses writes.
    assign m_en    = w_any_gnt && !w_gnt_bad;
    assign m_we    = m_en && d_gnt && d_we;
    assign m_addr  = m_en ? w_gnt_index : '0;
    assign m_wdata = m_en ? d_wdata : 32'd0;

    // ------------------------------------------------------------------
    // Streak counter and response tracking
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_streak    <= 4'd0;
            r_owner     <= OWN_NONE;
            r_was_write <= 1'b0;
            r_was_bad   <= 1'b0;
        end else begin
            if (!f_req || f_gnt) begin
                r_streak <= 4'd0;
            end else if (d_gnt && (r_streak < c_max_streak)) begin
                r_streak <= r_streak + 4'd1;
            end

            if (f_gnt) begin
                r_owner <= OWN_FETCH;
            end else if (d_gnt) begin
                r_owner <= OWN_DATA;
            end else begin
                r_owner <= OWN_NONE;
            end
            r_was_write <= d_gnt && d_we;
            r_was_bad   <= w_any_gnt && w_gnt_bad;
        end
    end

    // ------------------------------------------------------------------
    // Response routing; m_rdata is valid this cycle for last cycle's grant
    // ------------------------------------------------------------------
    always_comb begin
        f_rvalid = (r_owner == OWN_FETCH);
        f_err    = f_rvalid && r_was_bad;
        f_rdata  = 32'd0;
        if (f_rvalid) begin
            f_rdata = r_was_bad ? NOP_INSN : m_rdata;
        end

        d_rvalid = (r_owner == OWN_DATA);
        d_err    = d_rvalid && r_was_bad;
        d_rdata  = 32'd0;
        if (d_rvalid && !r_was_bad && !r_was_write) begin
            d_rdata = m_rdata;
        end
    end

endmodule : imem_port_arbiter
`default_nettype wire

// File: tb/tb_imem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_imem_port_arbiter
// Description : Self-checking bench for imem_port_arbiter. Directed steps
//               followed by random traffic, checked against a
//               transaction-level reference model with a shadow memory.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_imem_port_arbiter;

    localparam int          DEPTH       = 24581;
    localparam int          ADDR_W      = 15;
    localparam int          MAX_DSTREAK = 4;
    localparam logic [31:0] NOP         = 32'h0000_0013;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              f_req, d_req, d_we;
    logic [31:0]       f_addr, d_addr, d_wdata;
    logic              f_gnt, f_rvalid, f_err;
    logic [31:0]       f_rdata;
    logic              d_gnt, d_rvalid, d_err;
    logic [31:0]       d_rdata;
    logic              m_en, m_we;
    logic [ADDR_W-1:0] m_addr;
    logic [31:0]       m_wdata;
    logic [31:0]       m_rdata = 32'd0;

    int checks   = 0;
    int failures = 0;

    // environment memory array (write-first, one-cycle registered read)
    logic [31:0] mem    [DEPTH];
    // reference model state
    logic [31:0] shadow [DEPTH];
    int          fetch_wait;
    logic        p_fv, p_fe, p_dv, p_de;
    logic [31:0] p_fd, p_dd;

    imem_port_arbiter #(
        .ADDR_W      (ADDR_W),
        .DEPTH       (DEPTH),
        .MAX_DSTREAK (MAX_DSTREAK)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .f_req    (f_req),
        .f_addr   (f_addr),
        .f_gnt    (f_gnt),
        .f_rvalid (f_rvalid),
        .f_rdata  (f_rdata),
        .f_err    (f_err),
        .d_req    (d_req),
        .d_we     (d_we),
        .d_addr   (d_addr),
        .d_wdata  (d_wdata),
        .d_gnt    (d_gnt),
        .d_rvalid (d_rvalid),
        .d_rdata  (d_rdata),
        .d_err    (d_err),
        .m_en     (m_en),
        .m_we     (m_we),
        .m_addr   (m_addr),
        .m_wdata  (m_wdata),
        .m_rdata  (m_rdata)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (m_en && (int'(m_addr) < DEPTH)) begin
            if (m_we) begin
                mem[m_addr] <= m_wdata;
                m_rdata     <= m_wdata;
            end else begin
                m_rdata <= mem[m_addr];
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_responses();
        check("f_rvalid", 32'(f_rvalid), 32'(p_fv));
        check("f_err",    32'(f_err),    32'(p_fe));
        check("f_rdata",  f_rdata,       p_fd);
        check("d_rvalid", 32'(d_rvalid), 32'(p_dv));
        check("d_err",    32'(d_err),    32'(p_de));
        check("d_rdata",  d_rdata,       p_dd);
    endtask

    task automatic clear_model();
        fetch_wait = 0;
        p_fv = 1'b0; p_fe = 1'b0; p_fd = 32'd0;
        p_dv = 1'b0; p_de = 1'b0; p_dd = 32'd0;
    endtask

    // One clock cycle of traffic. Entered just after a rising edge, drives
    // the request, checks grants, memory port and last cycle's response at
    // the falling edge, then advances the model and returns after the next
    // rising edge.
    task automatic cyc(input logic fr, input logic [31:0] fa, input logic dr,
                       input logic dw, input logic [31:0] da, input logic [31:0] dwd);
        logic        eg_f, eg_d, bad, en;
        logic [31:0] a;
        int          idx;
        f_req = fr; f_addr = fa; d_req = dr; d_we = dw; d_addr = da; d_wdata = dwd;

        // fetch is served when data is idle, or after waiting MAX_DSTREAK cycles
        eg_f = fr && (!dr || fetch_wait >= MAX_DSTREAK);
        eg_d = dr && !eg_f;
        a    = eg_f ? fa : da;
        bad  = ((a % 4) != 0) || (a >= 32'(4 * DEPTH));
        en   = (eg_f || eg_d) && !bad;
        idx  = int'(a / 4);

        @(negedge clk);
        check("f_gnt", 32'(f_gnt), 32'(eg_f));
        check("d_gnt", 32'(d_gnt), 32'(eg_d));
        check("m_en",  32'(m_en),  32'(en));
        check("m_we",  32'(m_we),  32'(en && eg_d && dw));
        check("m_addr", 32'(m_addr), en ? 32'(idx) : 32'd0);
        check("m_wdata", m_wdata, en ? dwd : 32'd0);
        check_responses();

        p_fv = eg_f; p_fe = eg_f && bad; p_fd = 32'd0;
        p_dv = eg_d; p_de = eg_d && bad; p_dd = 32'd0;
        if (eg_f) begin
            if (bad) p_fd = NOP;
            else     p_fd = shadow[idx];
        end
        if (eg_d && !bad) begin
            if (dw) shadow[idx] = dwd;
            else    p_dd = shadow[idx];
        end
        fetch_wait = (fr && !eg_f) ? fetch_wait + 1 : 0;

        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] rand_addr();
        logic [31:0] a;
        case ($urandom_range(0, 15))
            0:       a = 32'(4 * $urandom_range(0, 7)) | 32'($urandom_range(1, 3));
            1:       a = 32'(4 * DEPTH) + 32'(4 * $urandom_range(0, 3));
            2:       a = 32'h8000_0000 | 32'(4 * $urandom_range(0, 7));
            3:       a = 32'(4 * (DEPTH - 1));
            default: a = 32'(4 * $urandom_range(0, 7));
        endcase
        return a;
    endfunction

    initial begin
        for (int i = 0; i < DEPTH; i++) begin
            mem[i]    = (32'(i) * 32'h9E37_79B1) ^ 32'h5A5A_0000;
            shadow[i] = (32'(i) * 32'h9E37_79B1) ^ 32'h5A5A_0000;
        end
        mem[4]    = 32'hDEAD_BEEF;
        shadow[4] = 32'hDEAD_BEEF;
        clear_model();

        // reset state
        rst_n = 1'b0;
        f_req = 1'b0; f_addr = 32'd0; d_req = 1'b0; d_we = 1'b0;
        d_addr = 32'd0; d_wdata = 32'd0;
        repeat (2) @(negedge clk);
        check_responses();
        check("reset m_en",  32'(m_en),  32'd0);
        check("reset m_we",  32'(m_we),  32'd0);
        check("reset f_gnt", 32'(f_gnt), 32'd0);
        check("reset d_gnt", 32'(d_gnt), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // fetch only, word 4 held three cycles
        repeat (3) cyc(1'b1, 32'h10, 1'b0, 1'b0, 32'd0, 32'd0);
        cyc(1'b0, 32'd0, 1'b0, 1'b0, 32'd0, 32'd0);

        // write then read back the same word
        cyc(1'b0, 32'd0, 1'b1, 1'b1, 32'h20, 32'h1234);
        cyc(1'b0, 32'd0, 1'b1, 1'b0, 32'h20, 32'd0);
        cyc(1'b0, 32'd0, 1'b0, 1'b0, 32'd0, 32'd0);

        // contention: D,D,D,D,F repeating
        for (int i = 0; i < 10; i++) cyc(1'b1, 32'h40 + 32'(4 * i), 1'b1, 1'b0, 32'h80 + 32'(4 * i), 32'd0);
        cyc(1'b0, 32'd0, 1'b0, 1'b0, 32'd0, 32'd0);

        // bad addresses
        cyc(1'b1, 32'h2, 1'b0, 1'b0, 32'd0, 32'd0);
        cyc(1'b1, 32'(4 * DEPTH), 1'b0, 1'b0, 32'd0, 32'd0);
        cyc(1'b1, 32'h8000_0010, 1'b0, 1'b0, 32'd0, 32'd0);
        cyc(1'b0, 32'd0, 1'b1, 1'b1, 32'h32, 32'hBAD0_BAD0);
        cyc(1'b0, 32'd0, 1'b1, 1'b1, 32'(4 * DEPTH), 32'hBAD1_BAD1);
        cyc(1'b0, 32'd0, 1'b1, 1'b0, 32'h30, 32'd0);
        cyc(1'b1, 32'(4 * (DEPTH - 1)), 1'b0, 1'b0, 32'd0, 32'd0);
        cyc(1'b0, 32'd0, 1'b0, 1'b0, 32'd0, 32'd0);
        check("array word 12 untouched", mem[12], shadow[12]);

        // reset during traffic: build a full streak, then reset after a data grant
        repeat (4) cyc(1'b1, 32'h40, 1'b1, 1'b0, 32'h80, 32'd0);
        rst_n = 1'b0;
        #1;
        check("d_rvalid in reset", 32'(d_rvalid), 32'd0);
        check("f_rvalid in reset", 32'(f_rvalid), 32'd0);
        clear_model();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        cyc(1'b1, 32'h40, 1'b1, 1'b0, 32'h80, 32'd0);
        cyc(1'b0, 32'd0, 1'b0, 1'b0, 32'd0, 32'd0);

        // random traffic on a small window of words plus bad addresses
        for (int i = 0; i < 400; i++) begin
            logic fr, dr, dw;
            logic [31:0] fa, da, wd;
            fr = ($urandom_range(0, 3) != 0);
            dr = ($urandom_range(0, 3) != 0);
            dw = ($urandom_range(0, 2) == 0);
            fa = rand_addr();
            da = rand_addr();
            wd = $urandom;
            cyc(fr, fa, dr, dw, da, wd);
        end
        cyc(1'b0, 32'd0, 1'b0, 1'b0, 32'd0, 32'd0);
        cyc(1'b0, 32'd0, 1'b0, 1'b0, 32'd0, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_imem_port_arbiter
`default_nettype wire
